// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg
// Shared definitions for the front-end hazard controller: scheduler state
// encoding, refill counter width and the default configuration values.
package hazard_ctrl_pkg;

    // Scheduler states: normal flow, post-redirect refill window, memory freeze.
    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_REFILL  = 2'd1,
        ST_MEMWAIT = 2'd2
    } hz_state_e;

    // Refill counter width covers the legal REFILL_CYCLES range 1..15.
    localparam int RC_W = 4;
    localparam logic [RC_W-1:0] RC_ONE = 4'd1;

    localparam int DEF_REFILL_CYCLES = 2;
    localparam int DEF_MAX_STALL     = 64;
    localparam int DEF_CNT_W         = 16;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// sat_counter
// Saturating up-counter with synchronous clear. Holds at MAX_VAL instead of
// wrapping.
// Ports:
//   clk   - clock
//   rst   - synchronous active-high reset to 0
//   clr   - synchronous clear (wins over inc)
//   inc   - increment request
//   cnt   - current count
module sat_counter #(
    parameter int           W       = 16,
    parameter logic [W-1:0] MAX_VAL = {W{1'b1}}
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear, saturating increment, or hold.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = {W{1'b0}};
        end else if (inc && (cnt_q != MAX_VAL)) begin
            cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= {W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
// Central stall/flush scheduler for the IF, IF/ID and ID/EXE latches.
// Resolves branch mispredict, data-memory busy, load-use and I-cache miss
// into one consistent stall/flush action per latch each cycle, sequences
// the post-redirect refill window and keeps saturating statistics plus a
// sticky stall watchdog.
// Ports:
//   CLK, RESET                       - clock, synchronous active-high reset
//   Mispredict, Mispredict_Target    - redirect request from EXE
//   DCache_Busy                      - freeze the whole pipe
//   LoadUse_Hazard                   - insert bubble into EXE
//   ICache_Miss                      - insert bubble into ID
//   STALL_IF/STALL_IFID/FLUSH_IFID/STALL_IDEXE/FLUSH_IDEXE - latch controls
//   Redirect_Valid, Redirect_Addr    - PC redirect
//   Stall_Cycles, Flush_Events       - saturating statistics
//   Stall_Timeout                    - sticky watchdog flag
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int REFILL_CYCLES = DEF_REFILL_CYCLES,
    parameter int MAX_STALL     = DEF_MAX_STALL,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             Mispredict,
    input  logic [31:0]      Mispredict_Target,
    input  logic             DCache_Busy,
    input  logic             LoadUse_Hazard,
    input  logic             ICache_Miss,
    output logic             STALL_IF,
    output logic             STALL_IFID,
    output logic             FLUSH_IFID,
    output logic             STALL_IDEXE,
    output logic             FLUSH_IDEXE,
    output logic             Redirect_Valid,
    output logic [31:0]      Redirect_Addr,
    output logic [CNT_W-1:0] Stall_Cycles,
    output logic [CNT_W-1:0] Flush_Events,
    output logic             Stall_Timeout
);

    localparam int RUN_W = $clog2(MAX_STALL + 1);
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(MAX_STALL - 1);
    localparam logic [RC_W-1:0]  RC_LOAD  = RC_W'(REFILL_CYCLES);

    hz_state_e        state_q;
    hz_state_e        state_d;
    hz_state_e        eff_state_s;
    logic [RC_W-1:0]  rc_q;
    logic [RC_W-1:0]  rc_d;
    logic             timeout_q;
    logic             timeout_d;
    logic             mp_accept_s;
    logic [RUN_W-1:0] run_cnt_s;

    // Leaving MEMWAIT resumes whatever the frozen refill count implies, and
    // that resumed state governs this cycle's outputs.
    always_comb begin
        eff_state_s = state_q;
        case (state_q)
            ST_MEMWAIT: eff_state_s = (rc_q != '0) ? ST_REFILL : ST_RUN;
            ST_REFILL:  eff_state_s = ST_REFILL;
            ST_RUN:     eff_state_s = ST_RUN;
            default:    eff_state_s = ST_RUN;
        endcase
    end

    // Priority arbitration: busy > mispredict > load-use > icache > refill.
    always_comb begin
        state_d        = state_q;
        rc_d           = rc_q;
        mp_accept_s    = 1'b0;
        STALL_IF       = 1'b0;
        STALL_IFID     = 1'b0;
        FLUSH_IFID     = 1'b0;
        STALL_IDEXE    = 1'b0;
        FLUSH_IDEXE    = 1'b0;
        Redirect_Valid = 1'b0;
        Redirect_Addr  = 32'h0000_0000;
        if (RESET) begin
            state_d = ST_RUN;
            rc_d    = '0;
        end else if (DCache_Busy) begin
            // Full freeze; a concurrent mispredict is re-presented by EXE.
            STALL_IF    = 1'b1;
            STALL_IFID  = 1'b1;
            STALL_IDEXE = 1'b1;
            state_d     = ST_MEMWAIT;
        end else if (Mispredict) begin
            FLUSH_IFID     = 1'b1;
            FLUSH_IDEXE    = 1'b1;
            Redirect_Valid = 1'b1;
            Redirect_Addr  = Mispredict_Target;
            mp_accept_s    = 1'b1;
            rc_d           = RC_LOAD;
            state_d        = ST_REFILL;
        end else begin
            // Every non-frozen, non-redirect refill cycle flushes IF/ID, so
            // each one consumes a refill slot regardless of lower sources.
            if (eff_state_s == ST_REFILL) begin
                if (rc_q <= RC_ONE) begin
                    rc_d    = '0;
                    state_d = ST_RUN;
                end else begin
                    rc_d    = rc_q - RC_ONE;
                    state_d = ST_REFILL;
                end
            end else begin
                state_d = ST_RUN;
            end

            if (LoadUse_Hazard) begin
                STALL_IF    = 1'b1;
                FLUSH_IDEXE = 1'b1;
                // In refill the IF/ID content is stale anyway: flush wins.
                if (eff_state_s == ST_REFILL) begin
                    FLUSH_IFID = 1'b1;
                end else begin
                    STALL_IFID = 1'b1;
                end
            end else if (ICache_Miss) begin
                STALL_IF   = 1'b1;
                FLUSH_IFID = 1'b1;
            end else if (eff_state_s == ST_REFILL) begin
                FLUSH_IFID = 1'b1;
            end else begin
                FLUSH_IFID = 1'b0;
            end
        end
    end

    // Watchdog sets on the edge where the stall run reaches MAX_STALL.
    always_comb begin
        timeout_d = timeout_q;
        if (DCache_Busy && (run_cnt_s >= RUN_LAST)) begin
            timeout_d = 1'b1;
        end else begin
            timeout_d = timeout_q;
        end
    end

    // State, refill count and watchdog registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= ST_RUN;
            rc_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rc_q      <= rc_d;
            timeout_q <= timeout_d;
        end
    end

    assign Stall_Timeout = timeout_q;

    sat_counter #(.W(CNT_W)) u_stall_cycles (
        .clk (CLK),
        .rst (RESET),
        .clr (1'b0),
        .inc (STALL_IF),
        .cnt (Stall_Cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_events (
        .clk (CLK),
        .rst (RESET),
        .clr (1'b0),
        .inc (mp_accept_s),
        .cnt (Flush_Events)
    );

    // Consecutive memory-stall run; any non-busy cycle ends the run.
    sat_counter #(.W(RUN_W), .MAX_VAL(RUN_W'(MAX_STALL))) u_stall_run (
        .clk (CLK),
        .rst (RESET),
        .clr (~DCache_Busy),
        .inc (DCache_Busy),
        .cnt (run_cnt_s)
    );

endmodule
